// File: rtl/analog_controls.sv
// Samples six ADC channels coherently every SAMPLE_DIV clocks, runs one shared IIR low-pass and deadzone classifier,
// and publishes all results together with a one-cycle upd strobe 13 cycles after the sample tick; there is no backpressure.
module analog_controls #(
  parameter int SAMPLE_DIV = 50000,
  parameter int SHIFT      = 3,
  parameter int CENTER     = 2048,
  parameter int DEADZONE   = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] a0,
  input  logic [11:0] a1,
  input  logic [11:0] a2,
  input  logic [11:0] a3,
  input  logic [11:0] a4,
  input  logic [11:0] a5,
  output logic [11:0] filt0,
  output logic [11:0] filt1,
  output logic [11:0] filt2,
  output logic [11:0] filt3,
  output logic [11:0] filt4,
  output logic [11:0] filt5,
  output logic [1:0]  dir0,
  output logic [1:0]  dir1,
  output logic [1:0]  dir2,
  output logic [1:0]  dir3,
  output logic [1:0]  dir4,
  output logic [1:0]  dir5,
  output logic        upd
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = 12 + SHIFT;
  localparam logic signed [13:0] HI = 14'(CENTER + DEADZONE);
  localparam logic signed [13:0] LO = 14'(CENTER - DEADZONE);

  typedef enum logic [1:0] {IDLE, FILT, CLASS, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic [2:0]      k;
  logic [11:0]     a_in [6];
  logic [11:0]     snap [6];
  logic [AW-1:0]   acc [6];
  logic [5:0]      primed;
  logic [11:0]     stage_filt [6];
  logic [1:0]      stage_dir [6];
  logic [11:0]     stage_filt_nxt [6];
  logic [1:0]      stage_dir_nxt [6];
  logic [AW-1:0]   acc_cur, acc_upd;
  logic [11:0]     f_cur;
  logic signed [13:0] f_s;
  logic [1:0]      dir_cur;

  assign a_in[0] = a0;
  assign a_in[1] = a1;
  assign a_in[2] = a2;
  assign a_in[3] = a3;
  assign a_in[4] = a4;
  assign a_in[5] = a5;

  assign tick = (cnt == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tick) state_nxt = FILT;
      FILT:  state_nxt = CLASS;
      CLASS: state_nxt = (k == 3'd5) ? DONE : FILT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    upd = (state == DONE);
  end

  // Sum is computed modulo 2^AW: the final value always fits, so transient wrap is harmless.
  always_comb begin
    acc_cur = acc[k];
    acc_upd = primed[k] ? (acc_cur + AW'(snap[k]) - (acc_cur >> SHIFT))
                        : (AW'(snap[k]) << SHIFT);
    f_cur   = 12'(acc_cur >> SHIFT);
    f_s     = $signed({2'b00, f_cur});
    dir_cur = 2'b00;
    if (f_s > HI) dir_cur = 2'b01;
    else if (f_s < LO) dir_cur = 2'b10;
    stage_filt_nxt    = stage_filt;
    stage_dir_nxt     = stage_dir;
    stage_filt_nxt[k] = f_cur;
    stage_dir_nxt[k]  = dir_cur;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k      <= '0;
      primed <= '0;
      for (int i = 0; i < 6; i++) begin
        snap[i]       <= '0;
        acc[i]        <= '0;
        stage_filt[i] <= '0;
        stage_dir[i]  <= '0;
      end
      filt0 <= '0; filt1 <= '0; filt2 <= '0; filt3 <= '0; filt4 <= '0; filt5 <= '0;
      dir0  <= '0; dir1  <= '0; dir2  <= '0; dir3  <= '0; dir4  <= '0; dir5  <= '0;
    end else begin
      case (state)
        IDLE: if (tick) begin
          for (int i = 0; i < 6; i++) snap[i] <= a_in[i];
          k <= '0;
        end
        FILT: begin
          acc[k]    <= acc_upd;
          primed[k] <= 1'b1;
        end
        CLASS: begin
          stage_filt <= stage_filt_nxt;
          stage_dir  <= stage_dir_nxt;
          if (k == 3'd5) begin
            // Channel 5 lands in the same edge, so publish from the next-stage view.
            filt0 <= stage_filt_nxt[0]; filt1 <= stage_filt_nxt[1]; filt2 <= stage_filt_nxt[2];
            filt3 <= stage_filt_nxt[3]; filt4 <= stage_filt_nxt[4]; filt5 <= stage_filt_nxt[5];
            dir0  <= stage_dir_nxt[0];  dir1  <= stage_dir_nxt[1];  dir2  <= stage_dir_nxt[2];
            dir3  <= stage_dir_nxt[3];  dir4  <= stage_dir_nxt[4];  dir5  <= stage_dir_nxt[5];
          end else begin
            k <= k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_analog_controls.sv
// Bench for analog_controls: directed sequence with random samples checked against an arithmetic reference model.
module tb_analog_controls;

  localparam int SD = 16;
  localparam int SH = 3;
  localparam int CTR = 2048;
  localparam int DZ = 200;

  logic        clk;
  logic        reset_n;
  logic [11:0] a [6];
  logic [11:0] filt [6];
  logic [1:0]  dir [6];
  logic        upd;

  int tests = 0;
  int fails = 0;

  int m_acc [6];
  bit m_primed [6];
  int m_filt [6];
  int m_dir [6];
  int snap_m [6];

  analog_controls #(.SAMPLE_DIV(SD), .SHIFT(SH), .CENTER(CTR), .DEADZONE(DZ)) dut (
    .clk(clk), .reset_n(reset_n),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .a4(a[4]), .a5(a[5]),
    .filt0(filt[0]), .filt1(filt[1]), .filt2(filt[2]),
    .filt3(filt[3]), .filt4(filt[4]), .filt5(filt[5]),
    .dir0(dir[0]), .dir1(dir[1]), .dir2(dir[2]),
    .dir3(dir[3]), .dir4(dir[4]), .dir5(dir[5]),
    .upd(upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [83:0] out_vec();
    logic [83:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*14 +: 14] = {filt[i], dir[i]};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_acc[i] = 0; m_primed[i] = 0; m_filt[i] = 0; m_dir[i] = 0;
    end
  endtask

  // One sample period per channel: prime on first use, else acc += sample - acc/2^SH.
  task automatic model_step();
    for (int i = 0; i < 6; i++) begin
      if (!m_primed[i]) begin
        m_acc[i] = snap_m[i] * (2 ** SH);
        m_primed[i] = 1;
      end else begin
        m_acc[i] = m_acc[i] + snap_m[i] - m_acc[i] / (2 ** SH);
      end
      m_filt[i] = m_acc[i] / (2 ** SH);
      if (m_filt[i] > CTR + DZ) m_dir[i] = 1;
      else if (m_filt[i] < CTR - DZ) m_dir[i] = 2;
      else m_dir[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s filt%0d", tag, i), 32'(filt[i]), 32'(m_filt[i]));
      chk($sformatf("%s dir%0d", tag, i), 32'(dir[i]), 32'(m_dir[i]));
    end
  endtask

  // Counts negedges until upd; flags code 11 or output changes outside the upd cycle.
  task automatic wait_upd(output int n, output bit bad, input int late_n, input int late_ch,
                          input logic [11:0] late_val);
    logic [83:0] prev;
    prev = out_vec();
    n = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) snap_m[i] = int'(a[i]);
    do begin
      @(negedge clk);
      n++;
      if (n == late_n) a[late_ch] = late_val;
      for (int i = 0; i < 6; i++) if (dir[i] === 2'b11) bad = 1;
      if (!upd && out_vec() !== prev) bad = 1;
      prev = out_vec();
    end while (!upd && n < 100);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset outputs zero", 32'(out_vec() == 84'd0), 1);
    chk("reset upd", 32'(upd), 0);
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  int  n;
  bit  bad;
  int  seen;
  logic [11:0] dz_val [4];
  int  dz_exp [4];

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) a[i] = '0;
    dz_val[0] = 12'd2248; dz_exp[0] = 0;
    dz_val[1] = 12'd2249; dz_exp[1] = 1;
    dz_val[2] = 12'd1848; dz_exp[2] = 0;
    dz_val[3] = 12'd1847; dz_exp[3] = 2;

    // First update after reset: a0 held at 3000, a1 at 0.
    enter_reset();
    a[0] = 12'd3000;
    reset_n = 1'b1;
    wait_upd(n, bad, -1, 0, '0);
    chk("first upd latency", 32'(n), 28);
    model_step();
    check_all("first");
    chk("first filt0 raw", 32'(filt[0]), 3000);
    chk("first dir5", 32'(dir[5]), 2);

    // Step a1 to full scale: 511 then 959.
    a[1] = 12'd4095;
    wait_upd(n, bad, -1, 0, '0);
    chk("step period", 32'(n), SD);
    model_step();
    check_all("step1");
    chk("step1 filt1", 32'(filt[1]), 511);
    wait_upd(n, bad, -1, 0, '0);
    chk("step period2", 32'(n), SD);
    model_step();
    check_all("step2");
    chk("step2 filt1", 32'(filt[1]), 959);
    chk("step2 dir1", 32'(dir[1]), 2);

    // Snapshot coherence: a4 changes one cycle after the tick.
    a[4] = 12'd1000;
    wait_upd(n, bad, 4, 4, 12'd4000);
    chk("coh period", 32'(n), SD);
    chk("coh stable", 32'(bad), 0);
    model_step();
    check_all("coh");

    // Random samples over ten periods, checking rate and stability too.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 6; i++) a[i] = 12'($urandom_range(0, 4095));
      wait_upd(n, bad, -1, 0, '0);
      chk($sformatf("rand%0d period", p), 32'(n), SD);
      chk($sformatf("rand%0d stable", p), 32'(bad), 0);
      model_step();
      check_all($sformatf("rand%0d", p));
    end

    // Reset during channel 3 processing.
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst outputs zero", 32'(out_vec() == 84'd0), 1);
    chk("midrst upd", 32'(upd), 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (upd) seen++;
    end
    chk("midrst no upd", 32'(seen), 0);
    model_reset();
    a[5] = 12'd100;
    reset_n = 1'b1;
    wait_upd(n, bad, -1, 0, '0);
    chk("midrst latency", 32'(n), 28);
    model_step();
    check_all("reprime");
    chk("reprime filt5", 32'(filt[5]), 100);

    // Deadzone boundaries on a2, fresh reset per value.
    for (int t = 0; t < 4; t++) begin
      enter_reset();
      for (int i = 0; i < 6; i++) a[i] = 12'($urandom_range(0, 4095));
      a[2] = dz_val[t];
      reset_n = 1'b1;
      wait_upd(n, bad, -1, 0, '0);
      chk($sformatf("dz%0d latency", t), 32'(n), 28);
      model_step();
      chk($sformatf("dz%0d dir2", t), 32'(dir[2]), 32'(dz_exp[t]));
      check_all($sformatf("dz%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
